tiny_core: RTL and testbench

8-bit multi-cycle accumulator-free CPU core with four general registers, an 8-bit program counter and separate code and data address spaces. It shares a single address/data bus; `ramsel` selects the target memory. It sits between two `tiny_ram` instances (code, data) and a simple 8-bit output latch and input port.

---
 rtl/tiny_pkg.sv | 41 ++++
 rtl/tiny_ram.sv | 26 ++
 rtl/tiny_core.sv | 145 ++++++++++++++
 tb/tb_tiny_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_pkg.sv
// Shared types for the tiny_core CPU: opcode set, FSM states, register index.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package tiny_pkg;

    // Upper nibble of every instruction byte
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_MOV = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_NOT = 4'h8,
        OP_LD  = 4'h9,
        OP_ST  = 4'hA,
        OP_OUT = 4'hB,
        OP_IN  = 4'hC,
        OP_JMP = 4'hD,
        OP_JZ  = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_IMM,
        S_IMMX,
        S_LOAD,
        S_LOADW,
        S_STORE,
        S_HALT
    } state_e;

    typedef logic [1:0] reg_idx_t;

    localparam logic [7:0] PC_RESET = 8'h00;

endpackage

// File: rtl/tiny_ram.sv
// 256x8 memory with registered read port; used once for code, once for data.
// Latency: read data appears on rdata one cycle after a selected read.
// Backpressure: none; rdata holds its last value when not reading.
module tiny_ram (
    input  logic       clk,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic [7:0] addr,
    input  logic       sel
);

    logic [7:0] mem [256];

    // Write and registered read, both gated by the select line; no reset on contents
    always_ff @(posedge clk) begin
        if (sel && write) begin
            mem[addr] <= wdata;
        end
        if (sel && read) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/tiny_core.sv
// 8-bit multi-cycle CPU: four registers, shared bus to code/data memories, output latch.
// Latency: 2 cycles for register/IO/NOP, 3 for ST, 4 for LD/LDI/JMP/JZ.
// Backpressure: none; memories are assumed to answer in exactly one cycle.
module tiny_core (
    input  logic       clk,
    input  logic       nreset,
    output logic       read,
    output logic       write,
    output logic [7:0] wdata,
    input  logic [7:0] rdata,
    output logic [7:0] addr,
    output logic       ramsel,
    output logic [7:0] out,
    input  logic [7:0] in
);

    import tiny_pkg::*;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] out_q, out_d;
    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];

    // EXEC decodes the byte arriving on rdata; later states use the latched ir
    opcode_e    ex_op, ir_op;
    reg_idx_t   ex_rd, ex_rs, ir_rd, ir_rs;
    logic [7:0] pc_inc;

    assign ex_op  = opcode_e'(rdata[7:4]);
    assign ex_rd  = rdata[3:2];
    assign ex_rs  = rdata[1:0];
    assign ir_op  = opcode_e'(ir_q[7:4]);
    assign ir_rd  = ir_q[3:2];
    assign ir_rs  = ir_q[1:0];
    assign pc_inc = pc_q + 8'd1;
    assign out    = out_q;

    // Next-state, program counter, register file and ALU
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        out_d   = out_q;
        regs_d  = regs_q;
        case (state_q)
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                ir_d    = rdata;
                pc_d    = pc_inc;
                state_d = S_FETCH;
                case (ex_op)
                    OP_NOP: ;
                    OP_LDI, OP_JMP, OP_JZ: state_d = S_IMM;
                    OP_MOV: regs_d[ex_rd] = regs_q[ex_rs];
                    OP_ADD: regs_d[ex_rd] = regs_q[ex_rd] + regs_q[ex_rs];
                    OP_SUB: regs_d[ex_rd] = regs_q[ex_rd] - regs_q[ex_rs];
                    OP_AND: regs_d[ex_rd] = regs_q[ex_rd] & regs_q[ex_rs];
                    OP_OR:  regs_d[ex_rd] = regs_q[ex_rd] | regs_q[ex_rs];
                    OP_XOR: regs_d[ex_rd] = regs_q[ex_rd] ^ regs_q[ex_rs];
                    OP_NOT: regs_d[ex_rd] = ~regs_q[ex_rd];
                    OP_LD:  state_d = S_LOAD;
                    OP_ST:  state_d = S_STORE;
                    OP_OUT: out_d = regs_q[ex_rd];
                    OP_IN:  regs_d[ex_rd] = in;
                    OP_HLT: state_d = S_HALT;
                endcase
            end
            S_IMM: state_d = S_IMMX;
            S_IMMX: begin
                // A taken jump overrides the post-immediate increment
                pc_d    = pc_inc;
                state_d = S_FETCH;
                case (ir_op)
                    OP_LDI:  regs_d[ir_rd] = rdata;
                    OP_JMP:  pc_d = rdata;
                    OP_JZ: begin
                        if (regs_q[ir_rd] == 8'h00) begin
                            pc_d = rdata;
                        end
                    end
                    default: ;
                endcase
            end
            S_LOAD:  state_d = S_LOADW;
            S_LOADW: begin
                regs_d[ir_rd] = rdata;
                state_d       = S_FETCH;
            end
            S_STORE: state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
        endcase
    end

    // Bus drive decoded from the current state; reset forces an idle bus so an
    // interrupted STORE never writes
    always_comb begin
        read   = 1'b0;
        write  = 1'b0;
        addr   = pc_q;
        ramsel = 1'b0;
        wdata  = 8'h00;
        if (nreset) begin
            addr = 8'h00;
        end else begin
            case (state_q)
                S_FETCH, S_IMM: read = 1'b1;
                S_LOAD: begin
                    addr   = regs_q[ir_rs];
                    ramsel = 1'b1;
                    read   = 1'b1;
                end
                S_LOADW: ramsel = 1'b1;
                S_STORE: begin
                    addr   = regs_q[ir_rs];
                    wdata  = regs_q[ir_rd];
                    ramsel = 1'b1;
                    write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Architectural state with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= 8'h00;
            out_q   <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
            regs_q  <= regs_d;
        end
    end

endmodule

// File: tb/tb_tiny_core.sv
// Bench for tiny_core with code and data tiny_ram instances and an instruction-level model.
// Latency: checks cycle-exact instruction timing via the halt fetch position.
// Backpressure: none on this bus; all waits are fixed cycle counts.
module tb_tiny_core;

    logic       clk    = 1'b0;
    logic       nreset = 1'b1;
    logic       read, write, ramsel;
    logic [7:0] wdata, rdata, addr, out_p;
    logic [7:0] in_p   = 8'h00;
    logic [7:0] code_rdata, data_rdata;
    logic       code_sel;

    assign code_sel = ~ramsel;
    assign rdata    = ramsel ? data_rdata : code_rdata;

    always #5 clk = ~clk;

    tiny_core dut (
        .clk    (clk),
        .nreset (nreset),
        .read   (read),
        .write  (write),
        .wdata  (wdata),
        .rdata  (rdata),
        .addr   (addr),
        .ramsel (ramsel),
        .out    (out_p),
        .in     (in_p)
    );

    tiny_ram u_code (
        .clk   (clk),
        .read  (read),
        .write (write),
        .wdata (wdata),
        .rdata (code_rdata),
        .addr  (addr),
        .sel   (code_sel)
    );

    tiny_ram u_data (
        .clk   (clk),
        .read  (read),
        .write (write),
        .wdata (wdata),
        .rdata (data_rdata),
        .addr  (addr),
        .sel   (ramsel)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory images and instruction-level reference model
    logic [7:0] m_code [256];
    logic [7:0] m_data [256];
    logic [7:0] d_init [256];
    logic [7:0] m_regs [4];
    logic [7:0] m_out;

    task automatic model_run(input logic [7:0] in_v, output int cycles,
                             output logic [7:0] hlt_pc, output bit done);
        logic [7:0] pc, inst, imm;
        logic [1:0] rd, rs;
        pc = 8'h00; cycles = 0; done = 1'b0; hlt_pc = 8'h00; m_out = 8'h00;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        for (int i = 0; i < 256; i++) m_data[i] = d_init[i];
        for (int step = 0; step < 200 && !done; step++) begin
            inst = m_code[pc];
            pc   = pc + 8'd1;
            rd   = inst[3:2];
            rs   = inst[1:0];
            case (inst[7:4])
                4'h0: cycles += 2;
                4'h1: begin imm = m_code[pc]; pc = pc + 8'd1; m_regs[rd] = imm; cycles += 4; end
                4'h2: begin m_regs[rd] = m_regs[rs]; cycles += 2; end
                4'h3: begin m_regs[rd] = m_regs[rd] + m_regs[rs]; cycles += 2; end
                4'h4: begin m_regs[rd] = m_regs[rd] - m_regs[rs]; cycles += 2; end
                4'h5: begin m_regs[rd] = m_regs[rd] & m_regs[rs]; cycles += 2; end
                4'h6: begin m_regs[rd] = m_regs[rd] | m_regs[rs]; cycles += 2; end
                4'h7: begin m_regs[rd] = m_regs[rd] ^ m_regs[rs]; cycles += 2; end
                4'h8: begin m_regs[rd] = ~m_regs[rd]; cycles += 2; end
                4'h9: begin m_regs[rd] = m_data[m_regs[rs]]; cycles += 4; end
                4'hA: begin m_data[m_regs[rs]] = m_regs[rd]; cycles += 3; end
                4'hB: begin m_out = m_regs[rd]; cycles += 2; end
                4'hC: begin m_regs[rd] = in_v; cycles += 2; end
                4'hD: begin imm = m_code[pc]; pc = imm; cycles += 4; end
                4'hE: begin
                    imm = m_code[pc];
                    pc  = pc + 8'd1;
                    if (m_regs[rd] == 8'h00) pc = imm;
                    cycles += 4;
                end
                default: begin hlt_pc = pc - 8'd1; cycles += 2; done = 1'b1; end
            endcase
        end
    endtask

    task automatic load_mems();
        for (int i = 0; i < 256; i++) begin
            u_code.mem[i] = m_code[i];
            u_data.mem[i] = d_init[i];
        end
    endtask

    task automatic gen_random();
        int n;
        logic [7:0] b;
        n = $urandom_range(20, 4);
        for (int i = 0; i < 256; i++) begin
            m_code[i] = 8'hF0;
            d_init[i] = 8'($urandom);
        end
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b[7:4] == 4'hF) b[7:4] = 4'($urandom_range(14, 0));
            m_code[i] = b;
        end
    endtask

    task automatic start_prog();
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        nreset = 1'b0;
    endtask

    // Reset, run for the expected cycle count, confirm halt position and stuck strobes
    task automatic run_prog(input string name, input logic [7:0] in_v, input int cycles,
                            input logic [7:0] hlt_pc);
        in_p   = in_v;
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        check({name, " reset bus"}, {read, write, ramsel, addr, wdata, out_p}, 64'h0);
        nreset = 1'b0;
        repeat (cycles - 2) @(negedge clk);
        check({name, " hlt fetch"}, {read, ramsel, addr}, {1'b1, 1'b0, hlt_pc});
        repeat (5) @(negedge clk);
        check({name, " halted"}, {read, write, addr}, {1'b0, 1'b0, hlt_pc + 8'd1});
    endtask

    typedef struct packed {
        logic [95:0] code;
        logic [7:0]  in_val;
        logic [31:0] exp_regs;
        logic [7:0]  exp_out;
        logic [15:0] cycles;
        logic [7:0]  hlt_pc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int         cyc, nd;
        logic [7:0] hpc, inv;
        bit         done;

        // code bytes | in | {r0,r1,r2,r3} | out | cycles | halt pc
        vecs[0] = '{code: 96'h10_05_14_03_31_B0_F0_00_00_00_00_00, in_val: 8'h00,
                    exp_regs: 32'h08_03_00_00, exp_out: 8'h08, cycles: 16'd14, hlt_pc: 8'h06};
        vecs[1] = '{code: 96'h10_00_14_01_41_C8_B8_F0_00_00_00_00, in_val: 8'hAA,
                    exp_regs: 32'hFF_01_AA_00, exp_out: 8'hAA, cycles: 16'd16, hlt_pc: 8'h07};
        vecs[2] = '{code: 96'h14_10_10_5A_A1_9D_BC_F0_00_00_00_00, in_val: 8'h00,
                    exp_regs: 32'h5A_10_00_5A, exp_out: 8'h5A, cycles: 16'd19, hlt_pc: 8'h07};
        vecs[3] = '{code: 96'h10_03_14_01_41_E0_0A_D0_04_00_B0_F0, in_val: 8'h00,
                    exp_regs: 32'h00_01_00_00, exp_out: 8'h00, cycles: 16'd38, hlt_pc: 8'h0B};
        vecs[4] = '{code: 96'h10_3C_14_0F_29_58_6C_7D_84_B4_00_F0, in_val: 8'h5C,
                    exp_regs: 32'h3C_F0_0C_33, exp_out: 8'hF0, cycles: 16'd24, hlt_pc: 8'h0B};

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 256; i++) begin
                m_code[i] = 8'hF0;
                d_init[i] = 8'h00;
            end
            for (int b = 0; b < 12; b++) m_code[b] = vecs[v].code[95 - 8*b -: 8];
            load_mems();
            run_prog($sformatf("vec%0d", v), vecs[v].in_val, int'(vecs[v].cycles), vecs[v].hlt_pc);
            check($sformatf("vec%0d regs", v),
                  {dut.regs_q[0], dut.regs_q[1], dut.regs_q[2], dut.regs_q[3]}, vecs[v].exp_regs);
            check($sformatf("vec%0d out", v), out_p, vecs[v].exp_out);
            if (v == 2) begin
                check("mem data[10]", u_data.mem[8'h10], 8'h5A);
                check("mem code[10]", u_code.mem[8'h10], 8'hF0);
            end
        end

        // Memory program again: reset during STORE must suppress the write
        for (int i = 0; i < 256; i++) begin
            m_code[i] = 8'hF0;
            d_init[i] = 8'h00;
        end
        for (int b = 0; b < 12; b++) m_code[b] = vecs[2].code[95 - 8*b -: 8];
        d_init[8'h10] = 8'h11;
        load_mems();
        start_prog();
        #1 check("first fetch", {read, ramsel, addr}, {1'b1, 1'b0, 8'h00});
        repeat (10) @(negedge clk);
        check("store strobe", write, 1'b1);
        nreset = 1'b1;
        #1 check("store gated by reset", write, 1'b0);
        @(negedge clk);
        check("aborted store data", u_data.mem[8'h10], 8'h11);
        check("aborted store pc", dut.pc_q, 8'h00);

        // Cycle-level bus checks then reset during LOAD
        d_init[8'h10] = 8'h00;
        load_mems();
        start_prog();
        repeat (9) @(negedge clk);
        check("exec no write", write, 1'b0);
        @(negedge clk);
        check("store bus", {write, ramsel, addr, wdata}, {1'b1, 1'b1, 8'h10, 8'h5A});
        repeat (3) @(negedge clk);
        check("load bus", {read, write, ramsel, addr}, {1'b1, 1'b0, 1'b1, 8'h10});
        nreset = 1'b1;
        #1 check("load gated by reset", {read, ramsel, addr}, {1'b0, 1'b0, 8'h00});
        @(negedge clk);
        check("mid reset regs", {dut.regs_q[0], dut.regs_q[1], dut.regs_q[2], dut.regs_q[3]}, 32'h0);
        check("mid reset pc/out", {dut.pc_q, out_p}, 16'h0);
        check("mid reset data kept", u_data.mem[8'h10], 8'h5A);

        // Random programs against the instruction-level model
        for (int t = 0; t < 25; t++) begin
            done = 1'b0;
            cyc  = 0;
            hpc  = 8'h00;
            inv  = 8'h00;
            for (int tries = 0; tries < 50 && !done; tries++) begin
                gen_random();
                inv = 8'($urandom);
                model_run(inv, cyc, hpc, done);
            end
            if (done) begin
                load_mems();
                run_prog($sformatf("rand%0d", t), inv, cyc, hpc);
                check($sformatf("rand%0d regs", t),
                      {dut.regs_q[0], dut.regs_q[1], dut.regs_q[2], dut.regs_q[3]},
                      {m_regs[0], m_regs[1], m_regs[2], m_regs[3]});
                check($sformatf("rand%0d out", t), out_p, m_out);
                nd = 0;
                for (int i = 0; i < 256; i++) begin
                    if (u_data.mem[i] !== m_data[i]) nd++;
                    if (u_code.mem[i] !== m_code[i]) nd++;
                end
                check($sformatf("rand%0d mem diffs", t), nd, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
